// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Optional perf counters: define WB_PERF_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ALU_VALID,
  input  logic [AW-1:0] ALU_ADDR,
  input  logic [DW-1:0] ALU_DATA,
  output logic          ALU_READY,
  input  logic          MEM_VALID,
  input  logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_DATA,
  output logic          MEM_READY,
  input  logic [AW-1:0] RD1ADDR,
  input  logic [AW-1:0] RD2ADDR,
  output logic          HAZARD,
  output logic          WRITE,
  output logic [AW-1:0] INADDRESS,
  output logic [DW-1:0] IN
`ifdef WB_PERF_EN
  ,
  output logic [15:0]   WR_COUNT,
  output logic [15:0]   MEM_STALL_COUNT
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;
  logic          iss_v;
  logic [AW-1:0] iss_a;
  logic [DW-1:0] iss_d;

  logic          write_q;
  logic [AW-1:0] inaddr_q;
  logic [DW-1:0] in_q;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign ALU_READY = !full;
  assign MEM_READY = !full;

  assign WRITE     = write_q;
  assign INADDRESS = inaddr_q;
  assign IN        = in_q;

  // Pick at most one write per cycle; loads win unless the FIFO is full
  always_comb begin
    iss_v = 1'b0;
    iss_a = '0;
    iss_d = '0;
    enq   = 1'b0;
    deq   = 1'b0;
    if (full) begin
      iss_v = 1'b1;
      iss_a = addr_q[rptr_q];
      iss_d = data_q[rptr_q];
      deq   = 1'b1;
    end else if (MEM_VALID) begin
      iss_v = 1'b1;
      iss_a = MEM_ADDR;
      iss_d = MEM_DATA;
      enq   = ALU_VALID;
    end else if (!empty) begin
      iss_v = 1'b1;
      iss_a = addr_q[rptr_q];
      iss_d = data_q[rptr_q];
      deq   = 1'b1;
      enq   = ALU_VALID;
    end else if (ALU_VALID) begin
      iss_v = 1'b1;
      iss_a = ALU_ADDR;
      iss_d = ALU_DATA;
    end
  end

  // Circular ALU buffer: storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        addr_q[wptr_q] <= ALU_ADDR;
        data_q[wptr_q] <= ALU_DATA;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (deq) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (enq && !deq) begin
        count_q <= count_q + 1'b1;
      end else if (deq && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Registered write port; address/data hold when idle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      write_q  <= 1'b0;
      inaddr_q <= '0;
      in_q     <= '0;
    end else begin
      write_q <= iss_v;
      if (iss_v) begin
        inaddr_q <= iss_a;
        in_q     <= iss_d;
      end
    end
  end

  // Flag any in-flight write that targets an operand being decoded
  always_comb begin : hz_b
    logic [PW-1:0] off;
    off    = '0;
    HAZARD = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr_q;
      if ({1'b0, off} < count_q &&
          (addr_q[i] == RD1ADDR ||
           addr_q[i] == RD2ADDR)) begin
        HAZARD = 1'b1;
      end
    end
    if (write_q &&
        (inaddr_q == RD1ADDR ||
         inaddr_q == RD2ADDR)) begin
      HAZARD = 1'b1;
    end
    if (MEM_VALID &&
        (MEM_ADDR == RD1ADDR ||
         MEM_ADDR == RD2ADDR)) begin
      HAZARD = 1'b1;
    end
    if (ALU_VALID &&
        (ALU_ADDR == RD1ADDR ||
         ALU_ADDR == RD2ADDR)) begin
      HAZARD = 1'b1;
    end
  end

`ifdef WB_PERF_EN
  logic [15:0] wr_cnt_q;
  logic [15:0] stall_cnt_q;

  assign WR_COUNT        = wr_cnt_q;
  assign MEM_STALL_COUNT = stall_cnt_q;

  // Saturating event counters for writes and blocked loads
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (write_q && wr_cnt_q != 16'hFFFF) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (MEM_VALID && !MEM_READY &&
          stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Build with WB_PERF_EN to also cover the counters.
module tb_regfile_wb_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ALU_VALID;
  logic [2:0] ALU_ADDR;
  logic [7:0] ALU_DATA;
  logic       ALU_READY;
  logic       MEM_VALID;
  logic [2:0] MEM_ADDR;
  logic [7:0] MEM_DATA;
  logic       MEM_READY;
  logic [2:0] RD1ADDR;
  logic [2:0] RD2ADDR;
  logic       HAZARD;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
`ifdef WB_PERF_EN
  logic [15:0] WR_COUNT;
  logic [15:0] MEM_STALL_COUNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DEPTH(2), .DW(8), .AW(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ALU_VALID (ALU_VALID),
    .ALU_ADDR  (ALU_ADDR),
    .ALU_DATA  (ALU_DATA),
    .ALU_READY (ALU_READY),
    .MEM_VALID (MEM_VALID),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .MEM_READY (MEM_READY),
    .RD1ADDR   (RD1ADDR),
    .RD2ADDR   (RD2ADDR),
    .HAZARD    (HAZARD),
    .WRITE     (WRITE),
    .INADDRESS (INADDRESS),
    .IN        (IN)
`ifdef WB_PERF_EN
    ,
    .WR_COUNT        (WR_COUNT),
    .MEM_STALL_COUNT (MEM_STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mv,
                       input logic [2:0] ma,
                       input logic [7:0] md,
                       input logic av,
                       input logic [2:0] aa,
                       input logic [7:0] ad);
    MEM_VALID = mv;
    MEM_ADDR  = ma;
    MEM_DATA  = md;
    ALU_VALID = av;
    ALU_ADDR  = aa;
    ALU_DATA  = ad;
  endtask

  // one cycle: drive at negedge, check readies, then outputs after posedge
  task automatic step(input string tag,
                      input logic mv,
                      input logic [2:0] ma,
                      input logic [7:0] md,
                      input logic av,
                      input logic [2:0] aa,
                      input logic [7:0] ad,
                      input logic er,
                      input logic ew,
                      input logic [2:0] ea,
                      input logic [7:0] ed);
    @(negedge CLK);
    drive(mv, ma, md, av, aa, ad);
    #1;
    chk({tag, ".ardy"}, 32'(ALU_READY), 32'(er));
    chk({tag, ".mrdy"}, 32'(MEM_READY), 32'(er));
    @(posedge CLK);
    #1;
    chk({tag, ".wr"}, 32'(WRITE), 32'(ew));
    chk({tag, ".addr"}, 32'(INADDRESS), 32'(ea));
    chk({tag, ".data"}, 32'(IN), 32'(ed));
  endtask

  initial begin
    RESET   = 1'b0;
    RD1ADDR = 3'd0;
    RD2ADDR = 3'd0;
    drive(1'b1, 3'($urandom), 8'($urandom),
          1'b1, 3'($urandom), 8'($urandom));
    @(negedge CLK);
    @(negedge CLK);
    chk("rst.wr", 32'(WRITE), 32'd0);
    chk("rst.addr", 32'(INADDRESS), 32'd0);
    chk("rst.data", 32'(IN), 32'd0);
    chk("rst.ardy", 32'(ALU_READY), 32'd1);
    chk("rst.mrdy", 32'(MEM_READY), 32'd1);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    RESET = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 8'h00);
    step("idle2", 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 8'h00);

    step("byp", 0, 0, 0, 1, 3, 8'h5A, 1, 1, 3'd3, 8'h5A);
    step("byp+1", 0, 0, 0, 0, 0, 0, 1, 0, 3'd3, 8'h5A);

    step("col", 1, 2, 8'hC3, 1, 4, 8'h11, 1, 1, 3'd2, 8'hC3);
    step("col+1", 0, 0, 0, 0, 0, 0, 1, 1, 3'd4, 8'h11);
    step("col+2", 0, 0, 0, 0, 0, 0, 1, 0, 3'd4, 8'h11);

    step("full1", 1, 1, 8'hA0, 1, 5, 8'hB0, 1, 1, 3'd1, 8'hA0);
    step("full2", 1, 2, 8'hA1, 1, 6, 8'hB1, 1, 1, 3'd2, 8'hA1);
    step("full3", 1, 3, 8'hA2, 1, 7, 8'hB2, 0, 1, 3'd5, 8'hB0);
    step("full4", 1, 3, 8'hA2, 1, 7, 8'hB2, 1, 1, 3'd3, 8'hA2);
    step("full5", 0, 0, 0, 0, 0, 0, 0, 1, 3'd6, 8'hB1);
    step("full6", 0, 0, 0, 0, 0, 0, 1, 1, 3'd7, 8'hB2);
    step("full7", 0, 0, 0, 0, 0, 0, 1, 0, 3'd7, 8'hB2);

    step("hz0", 1, 1, 8'h11, 1, 5, 8'h55, 1, 1, 3'd1, 8'h11);
    @(negedge CLK);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    RD1ADDR = 3'd5;
    RD2ADDR = 3'd0;
    #1;
    chk("hz.fifo1", 32'(HAZARD), 32'd1);
    RD1ADDR = 3'd0;
    RD2ADDR = 3'd5;
    #1;
    chk("hz.fifo2", 32'(HAZARD), 32'd1);
    RD1ADDR = 3'd4;
    RD2ADDR = 3'd3;
    #1;
    chk("hz.miss", 32'(HAZARD), 32'd0);
    RD1ADDR = 3'd5;
    RD2ADDR = 3'd0;
    @(posedge CLK);
    #1;
    chk("hz.wr", 32'(WRITE), 32'd1);
    chk("hz.addr", 32'(INADDRESS), 32'd5);
    chk("hz.inflt", 32'(HAZARD), 32'd1);
    @(posedge CLK);
    #1;
    chk("hz.wr0", 32'(WRITE), 32'd0);
    chk("hz.clear", 32'(HAZARD), 32'd0);
    @(negedge CLK);
    drive(1'b1, 3'd5, 8'h77, 1'b0, 3'd0, 8'd0);
    #1;
    chk("hz.mem", 32'(HAZARD), 32'd1);
    drive(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 8'h77);
    #1;
    chk("hz.alu", 32'(HAZARD), 32'd1);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);

    step("mr1", 1, 1, 8'hC1, 1, 5, 8'hD1, 1, 1, 3'd1, 8'hC1);
    step("mr2", 1, 2, 8'hC2, 1, 6, 8'hD2, 1, 1, 3'd2, 8'hC2);
    @(negedge CLK);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    #2;
    RESET = 1'b0;
    #1;
    chk("mr.wr", 32'(WRITE), 32'd0);
    chk("mr.addr", 32'(INADDRESS), 32'd0);
    chk("mr.data", 32'(IN), 32'd0);
    chk("mr.ardy", 32'(ALU_READY), 32'd1);
`ifdef WB_PERF_EN
    chk("mr.wrcnt", 32'(WR_COUNT), 32'd0);
    chk("mr.stall", 32'(MEM_STALL_COUNT), 32'd0);
`endif
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("mr.stale", 32'(WRITE), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
